// File: rtl/ysyx_22050243_lsu_if.sv
`default_nettype none
// ============================================================================
// Module     : ysyx_22050243_lsu_if
// Description: Bundles the EXU-side input handshake, memory bus and writeback
//              handshake of the load/store unit.
// Revision   : 1.0 - initial release
// ============================================================================
interface ysyx_22050243_lsu_if #(
    parameter int WIDTH = 64
);
    // Instruction handshake from execute
    logic               in_valid;
    logic               in_ready;
    logic               in_mem;
    logic [3:0]         in_op;
    logic [WIDTH-1:0]   in_addr;
    logic [WIDTH-1:0]   in_wdata;
    logic [4:0]         in_rd;
    // Memory bus
    logic               mem_req;
    logic               mem_we;
    logic [WIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic [WIDTH/8-1:0] mem_wmask;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [WIDTH-1:0]   mem_rdata;
    // Writeback handshake
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [4:0]         out_rd;
    logic               out_misalign;

    // The LSU itself
    modport slave (
        input  in_valid, in_mem, in_op, in_addr, in_wdata, in_rd,
        output in_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output out_valid, out_data, out_rd, out_misalign,
        input  out_ready
    );

    // The surrounding pipeline / bus environment
    modport master (
        output in_valid, in_mem, in_op, in_addr, in_wdata, in_rd,
        input  in_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  out_valid, out_data, out_rd, out_misalign,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050243_lsu.sv
`default_nettype none
// ============================================================================
// Module     : ysyx_22050243_lsu
// Description: Non-pipelined load/store stage: one aligned bus access per
//              instruction, load extraction/extension, result to writeback.
// Revision   : 1.0 - initial release
// ============================================================================
module ysyx_22050243_lsu #(
    parameter int WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22050243_lsu_if.slave        lsu_io
);
    localparam int NBYTES = WIDTH / 8;
    localparam int OFFW   = $clog2(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [4:0]         rd_q, rd_d;
    logic               misalign_q, misalign_d;

    logic               in_misalign;
    logic [OFFW-1:0]    off;
    logic [WIDTH-1:0]   rshift;
    logic [WIDTH-1:0]   load_val;
    logic [NBYTES-1:0]  mask_base;

    always_comb begin
        in_misalign = 1'b0;
        case (lsu_io.in_op[1:0])
            2'd1:    in_misalign = lsu_io.in_addr[0];
            2'd2:    in_misalign = |lsu_io.in_addr[1:0];
            2'd3:    in_misalign = |lsu_io.in_addr[OFFW-1:0];
            default: in_misalign = 1'b0;
        endcase
    end

    assign off    = addr_q[OFFW-1:0];
    assign rshift = lsu_io.mem_rdata >> {off, 3'b000};

    // op[2] selects zero extension; doublewords have nothing to extend
    always_comb begin
        load_val = rshift;
        case (op_q[1:0])
            2'd0: load_val = {{(WIDTH-8){~op_q[2] & rshift[7]}},   rshift[7:0]};
            2'd1: load_val = {{(WIDTH-16){~op_q[2] & rshift[15]}}, rshift[15:0]};
            2'd2: load_val = {{(WIDTH-32){~op_q[2] & rshift[31]}}, rshift[31:0]};
            default: load_val = rshift;
        endcase
    end

    always_comb begin
        mask_base = NBYTES'(8'hFF);
        case (op_q[1:0])
            2'd0:    mask_base = NBYTES'(8'h01);
            2'd1:    mask_base = NBYTES'(8'h03);
            2'd2:    mask_base = NBYTES'(8'h0F);
            default: mask_base = NBYTES'(8'hFF);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            rd_q       <= 5'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rd_d       = rd_q;
        misalign_d = misalign_q;

        lsu_io.in_ready     = (state_q == S_IDLE);
        lsu_io.mem_req      = 1'b0;
        lsu_io.mem_we       = 1'b0;
        lsu_io.mem_addr     = {addr_q[WIDTH-1:OFFW], {OFFW{1'b0}}};
        lsu_io.mem_wdata    = wdata_q << {off, 3'b000};
        lsu_io.mem_wmask    = '0;
        lsu_io.out_valid    = 1'b0;
        lsu_io.out_data     = data_q;
        lsu_io.out_rd       = rd_q;
        lsu_io.out_misalign = misalign_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_io.in_valid) begin
                    op_d       = lsu_io.in_op;
                    addr_d     = lsu_io.in_addr;
                    wdata_d    = lsu_io.in_wdata;
                    misalign_d = 1'b0;
                    if (!lsu_io.in_mem) begin
                        data_d  = lsu_io.in_addr;
                        rd_d    = lsu_io.in_rd;
                        state_d = S_RESP;
                    end else if (in_misalign) begin
                        data_d     = '0;
                        rd_d       = 5'd0;
                        misalign_d = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        // Stores report rd=0 and data=0; loads overwrite data in WAIT
                        data_d  = '0;
                        rd_d    = lsu_io.in_op[3] ? 5'd0 : lsu_io.in_rd;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                lsu_io.mem_req = 1'b1;
                lsu_io.mem_we  = op_q[3];
                if (lsu_io.mem_gnt) begin
                    state_d = op_q[3] ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (lsu_io.mem_rvalid) begin
                    data_d  = load_val;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                lsu_io.out_valid = 1'b1;
                if (lsu_io.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus request and result valid are withdrawn as soon as reset is seen
        if (rst) begin
            lsu_io.mem_req   = 1'b0;
            lsu_io.mem_we    = 1'b0;
            lsu_io.out_valid = 1'b0;
        end
        lsu_io.mem_wmask = lsu_io.mem_we ? (mask_base << off) : '0;
    end
endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050243_lsu.sv
`default_nettype none
// ============================================================================
// Module     : tb_ysyx_22050243_lsu
// Description: Directed self-checking bench for the load/store unit with a
//              result scoreboard.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050243_lsu;
    localparam int WIDTH = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050243_lsu_if #(.WIDTH(WIDTH)) lsu_io ();

    ysyx_22050243_lsu #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .lsu_io (lsu_io)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted result is popped and compared
    always @(negedge clk) begin
        if (!rst && lsu_io.out_valid === 1'b1 && lsu_io.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_data", lsu_io.out_data, e.data);
                chk("out_rd", 64'(lsu_io.out_rd), 64'(e.rd));
                chk("out_misalign", 64'(lsu_io.out_misalign), 64'(e.mis));
            end
        end
    end

    task automatic accept(input logic mem, input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd);
        @(negedge clk);
        chk("in_ready_idle", 64'(lsu_io.in_ready), 64'd1);
        lsu_io.in_valid = 1'b1;
        lsu_io.in_mem   = mem;
        lsu_io.in_op    = op;
        lsu_io.in_addr  = addr;
        lsu_io.in_wdata = wd;
        lsu_io.in_rd    = rd;
        @(posedge clk);
        #1;
        lsu_io.in_valid = 1'b0;
        lsu_io.in_addr  = 64'($urandom);
        lsu_io.in_wdata = 64'($urandom);
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [3:0] op, input logic [4:0] rd,
                           input logic [63:0] rdata, input logic [63:0] exp_data);
        sb_q.push_back('{data: exp_data, rd: rd, mis: 1'b0});
        accept(1'b1, op, addr, 64'd0, rd);
        @(negedge clk);
        chk("ld_req", 64'(lsu_io.mem_req), 64'd1);
        chk("ld_we", 64'(lsu_io.mem_we), 64'd0);
        chk("ld_wmask", 64'(lsu_io.mem_wmask), 64'd0);
        chk("ld_addr", lsu_io.mem_addr, addr & ~64'h7);
        lsu_io.mem_gnt = 1'b1;
        @(posedge clk);
        #1 lsu_io.mem_gnt = 1'b0;
        @(negedge clk);
        chk("ld_wait_noreq", 64'(lsu_io.mem_req), 64'd0);
        chk("ld_wait_novalid", 64'(lsu_io.out_valid), 64'd0);
        lsu_io.mem_rvalid = 1'b1;
        lsu_io.mem_rdata  = rdata;
        @(posedge clk);
        #1 lsu_io.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("ld_out_valid", 64'(lsu_io.out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [63:0] addr, input logic [3:0] op, input logic [63:0] wd,
                            input int dly, input logic [7:0] exp_mask, input logic [63:0] exp_wd);
        sb_q.push_back('{data: 64'd0, rd: 5'd0, mis: 1'b0});
        accept(1'b1, op, addr, wd, 5'd9);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("st_req_held", 64'(lsu_io.mem_req), 64'd1);
            chk("st_addr_held", lsu_io.mem_addr, addr & ~64'h7);
        end
        @(negedge clk);
        chk("st_req", 64'(lsu_io.mem_req), 64'd1);
        chk("st_we", 64'(lsu_io.mem_we), 64'd1);
        chk("st_wmask", 64'(lsu_io.mem_wmask), 64'(exp_mask));
        chk("st_wdata", lsu_io.mem_wdata, exp_wd);
        chk("st_addr", lsu_io.mem_addr, addr & ~64'h7);
        lsu_io.mem_gnt = 1'b1;
        @(posedge clk);
        #1 lsu_io.mem_gnt = 1'b0;
        @(negedge clk);
        chk("st_noreq", 64'(lsu_io.mem_req), 64'd0);
        chk("st_out_valid", 64'(lsu_io.out_valid), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        lsu_io.in_valid   = 1'b0;
        lsu_io.in_mem     = 1'b0;
        lsu_io.in_op      = 4'd0;
        lsu_io.in_addr    = '0;
        lsu_io.in_wdata   = '0;
        lsu_io.in_rd      = 5'd0;
        lsu_io.mem_gnt    = 1'b0;
        lsu_io.mem_rvalid = 1'b0;
        lsu_io.mem_rdata  = '0;
        lsu_io.out_ready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(lsu_io.in_ready), 64'd1);
        chk("rst_out_valid", 64'(lsu_io.out_valid), 64'd0);
        chk("rst_mem_req", 64'(lsu_io.mem_req), 64'd0);
        chk("rst_mem_we", 64'(lsu_io.mem_we), 64'd0);
        chk("rst_wmask", 64'(lsu_io.mem_wmask), 64'd0);
        chk("rst_out_data", lsu_io.out_data, 64'd0);
        chk("rst_out_rd", 64'(lsu_io.out_rd), 64'd0);
        chk("rst_misalign", 64'(lsu_io.out_misalign), 64'd0);

        // Passthrough: result one cycle after accept, no bus activity
        sb_q.push_back('{data: 64'h1234, rd: 5'd5, mis: 1'b0});
        accept(1'b0, 4'd0, 64'h1234, 64'd0, 5'd5);
        @(negedge clk);
        chk("pt_out_valid", 64'(lsu_io.out_valid), 64'd1);
        chk("pt_no_req", 64'(lsu_io.mem_req), 64'd0);
        @(posedge clk);
        #1;

        // Loads
        do_load(64'h8000_0003, 4'b0000, 5'd7, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(64'h8000_0004, 4'b0110, 5'd3, 64'hF000_0001_DEAD_BEEF, 64'h0000_0000_F000_0001);
        do_load(64'h8000_0002, 4'b0001, 5'd11, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        do_load(64'h8000_0001, 4'b0100, 5'd12, 64'h0000_0000_0000_F100, 64'h0000_0000_0000_00F1);
        do_load(64'h8000_0008, 4'b0011, 5'd13, 64'h8765_4321_0FED_CBA9, 64'h8765_4321_0FED_CBA9);

        // Stores
        do_store(64'h8000_0006, 4'b1001, 64'hABCD, 3, 8'hC0, 64'hABCD_0000_0000_0000);
        do_store(64'h8000_0005, 4'b1000, 64'h77, 0, 8'h20, 64'h0000_7700_0000_0000);
        do_store(64'h8000_0010, 4'b1011, 64'h0123_4567_89AB_CDEF, 1, 8'hFF, 64'h0123_4567_89AB_CDEF);

        // Misaligned doubleword load held by back-pressure
        lsu_io.out_ready = 1'b0;
        sb_q.push_back('{data: 64'd0, rd: 5'd0, mis: 1'b1});
        accept(1'b1, 4'b0011, 64'h8000_0004, 64'd0, 5'd4);
        @(negedge clk);
        chk("mis_no_req", 64'(lsu_io.mem_req), 64'd0);
        chk("mis_valid", 64'(lsu_io.out_valid), 64'd1);
        chk("mis_flag", 64'(lsu_io.out_misalign), 64'd1);
        chk("mis_data", lsu_io.out_data, 64'd0);
        @(negedge clk);
        chk("mis_hold_valid", 64'(lsu_io.out_valid), 64'd1);
        chk("mis_hold_flag", 64'(lsu_io.out_misalign), 64'd1);
        chk("mis_in_ready", 64'(lsu_io.in_ready), 64'd0);
        @(posedge clk);
        #1 lsu_io.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mis_released", 64'(lsu_io.out_valid), 64'd0);

        // Reset while waiting for load data, then a stray rvalid
        accept(1'b1, 4'b0011, 64'h8000_0000, 64'd0, 5'd6);
        @(negedge clk);
        lsu_io.mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        lsu_io.mem_gnt = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        chk("rstw_out_valid", 64'(lsu_io.out_valid), 64'd0);
        chk("rstw_mem_req", 64'(lsu_io.mem_req), 64'd0);
        @(posedge clk);
        #1;
        rst               = 1'b0;
        lsu_io.mem_rvalid = 1'b1;
        lsu_io.mem_rdata  = 64'h5555_AAAA_5555_AAAA;
        @(negedge clk);
        chk("rstw_in_ready", 64'(lsu_io.in_ready), 64'd1);
        @(posedge clk);
        #1 lsu_io.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("rstw_stray_valid", 64'(lsu_io.out_valid), 64'd0);
        chk("rstw_stray_ready", 64'(lsu_io.in_ready), 64'd1);

        // Every pushed result must have been produced
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
